// File: rtl/lsu_array.sv
// lsu_array: multi-lane load/store unit for one SIMD core.
// Captures a per-lane address/data vector plus an active-lane mask, then
// issues the active lanes one at a time, lowest lane first, on a single
// shared data-memory port. With COALESCE=1, one read return also fills
// every other pending lane that carries the same address.
//
// Ports:
//   clk, rst_n       clock (rising edge) and synchronous active-low reset
//   enable           0 = all state and outputs hold
//   simd_state       SIMD controller state (REQUEST starts, UPDATE releases)
//   MEM_READ/WRITE   operation select; read wins when both are high
//   lane_mask        active lanes, sampled at capture only
//   rm_data          per-lane address vector, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rn_data          per-lane store data, same packing
//   mem_read_ack     read completion, mem_read_data valid in the same cycle
//   mem_write_ack    write completion
//   mem_read_data    read return data
//   mem_read_valid   read request, held until acknowledged
//   mem_write_valid  write request, held until acknowledged
//   mem_addr         request address
//   mem_write_data   store data
//   lsu_state        IDLE / REQUESTING / WAITING / DONE
//   lsu_read_out     per-lane load results, same packing as rm_data
module lsu_array #(
  parameter int NUM_LANES  = 4,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 7,
  parameter int COALESCE   = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic [2:0]                      simd_state,
  input  logic                            MEM_READ,
  input  logic                            MEM_WRITE,
  input  logic [NUM_LANES-1:0]            lane_mask,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] rm_data,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] rn_data,
  input  logic                            mem_read_ack,
  input  logic                            mem_write_ack,
  input  logic [DATA_WIDTH-1:0]           mem_read_data,
  output logic                            mem_read_valid,
  output logic                            mem_write_valid,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [DATA_WIDTH-1:0]           mem_write_data,
  output logic [1:0]                      lsu_state,
  output logic [NUM_LANES*DATA_WIDTH-1:0] lsu_read_out
);

  // SIMD controller state encodings shared with the core.
  localparam logic [2:0] SIMD_REQUEST = 3'b011;
  localparam logic [2:0] SIMD_UPDATE  = 3'b110;

  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [1:0] {
    LSU_IDLE       = 2'b00,
    LSU_REQUESTING = 2'b01,
    LSU_WAITING    = 2'b10,
    LSU_DONE       = 2'b11
  } lsu_state_t;

  lsu_state_t state, state_next;

  logic [NUM_LANES-1:0]  pending;
  logic [NUM_LANES-1:0]  fill;
  logic                  op_read;
  logic [ADDR_WIDTH-1:0] addr_q   [NUM_LANES];
  logic [DATA_WIDTH-1:0] data_q   [NUM_LANES];
  logic [DATA_WIDTH-1:0] read_out [NUM_LANES];
  logic [LANE_W-1:0]     cur_lane;
  logic [LANE_W-1:0]     sel_lane;
  logic                  sel_found;
  logic                  capture;
  logic                  ack;

  assign capture = (state == LSU_IDLE) && (simd_state == SIMD_REQUEST) &&
                   (MEM_READ || MEM_WRITE);

  // Only an ack that matches the captured op and arrives while its request
  // is outstanding counts; anything else is ignored.
  assign ack = (state == LSU_WAITING) &&
               (op_read ? (mem_read_ack && mem_read_valid)
                        : (mem_write_ack && mem_write_valid));

  // Lowest-index pending lane.
  always_comb begin
    sel_lane  = '0;
    sel_found = 1'b0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (pending[i] && !sel_found) begin
        sel_lane  = LANE_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  // Lanes retired by an ack on the current lane: the lane itself, plus (for
  // coalesced reads) every still-pending lane with the same address.
  always_comb begin
    fill = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (LANE_W'(i) == cur_lane) begin
        fill[i] = 1'b1;
      end else if (op_read && (COALESCE != 0) && pending[i] &&
                   (addr_q[i] == addr_q[cur_lane])) begin
        fill[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= LSU_IDLE;
    end else if (enable) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      LSU_IDLE: begin
        if (capture) begin
          state_next = (lane_mask == '0) ? LSU_DONE : LSU_REQUESTING;
        end
      end
      LSU_REQUESTING: state_next = LSU_WAITING;
      LSU_WAITING: begin
        if (ack) begin
          state_next = ((pending & ~fill) == '0) ? LSU_DONE : LSU_REQUESTING;
        end
      end
      LSU_DONE: begin
        if (simd_state == SIMD_UPDATE) begin
          state_next = LSU_IDLE;
        end
      end
      default: state_next = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending         <= '0;
      op_read         <= 1'b0;
      cur_lane        <= '0;
      mem_read_valid  <= 1'b0;
      mem_write_valid <= 1'b0;
      mem_addr        <= '0;
      mem_write_data  <= '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        addr_q[i]   <= '0;
        data_q[i]   <= '0;
        read_out[i] <= '0;
      end
    end else if (enable) begin
      case (state)
        LSU_IDLE: begin
          if (capture) begin
            op_read <= MEM_READ;
            pending <= lane_mask;
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
              addr_q[i] <= rm_data[i*DATA_WIDTH +: ADDR_WIDTH];
              data_q[i] <= rn_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
        LSU_REQUESTING: begin
          cur_lane <= sel_lane;
          mem_addr <= addr_q[sel_lane];
          if (op_read) begin
            mem_read_valid <= 1'b1;
          end else begin
            mem_write_valid <= 1'b1;
            mem_write_data  <= data_q[sel_lane];
          end
        end
        LSU_WAITING: begin
          if (ack) begin
            mem_read_valid  <= 1'b0;
            mem_write_valid <= 1'b0;
            pending         <= pending & ~fill;
            if (op_read) begin
              for (int unsigned i = 0; i < NUM_LANES; i++) begin
                if (fill[i]) begin
                  read_out[i] <= mem_read_data;
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign lsu_state = state;

  always_comb begin
    lsu_read_out = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      lsu_read_out[i*DATA_WIDTH +: DATA_WIDTH] = read_out[i];
    end
  end

endmodule

// File: tb/tb_lsu_array.sv
// Testbench for lsu_array: directed vector table, hand-written multi-cycle
// sequences, and randomized operations checked against a lane-order model.
module tb_lsu_array;
  localparam int NL = 4;
  localparam int DW = 64;
  localparam int AW = 7;

  localparam logic [2:0] SIMD_IDLE    = 3'b000;
  localparam logic [2:0] SIMD_REQUEST = 3'b011;
  localparam logic [2:0] SIMD_WAIT    = 3'b100;
  localparam logic [2:0] SIMD_UPDATE  = 3'b110;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef struct {
    bit wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  typedef struct {
    bit rd;
    bit wr;
    logic [NL-1:0] mask;
    logic [NL-1:0][AW-1:0] a;
    logic [NL-1:0][DW-1:0] d;
    int exp_txn;
    int exp_cycles;
    logic [NL-1:0][DW-1:0] exp_out;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, enable, MEM_READ, MEM_WRITE;
  logic [2:0] simd_state, simd1;
  logic [NL-1:0] lane_mask;
  logic [NL*DW-1:0] rm_data, rn_data;

  // dut0 (coalescing) memory side
  logic rack_r, wack_r, winj;
  logic mem_read_ack, mem_write_ack;
  logic [DW-1:0] mem_read_data;
  logic mem_read_valid, mem_write_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_write_data;
  logic [1:0] lsu_state;
  logic [NL*DW-1:0] lsu_read_out;
  assign mem_read_ack  = rack_r;
  assign mem_write_ack = wack_r | winj;

  // dut1 (non-coalescing) memory side
  logic rack1, wack1;
  logic [DW-1:0] rdata1;
  logic rvalid1, wvalid1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic [1:0] state1;
  logic [NL*DW-1:0] out1;

  lsu_array #(.NUM_LANES(NL), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .COALESCE(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .simd_state(simd_state),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .lane_mask(lane_mask),
    .rm_data(rm_data), .rn_data(rn_data),
    .mem_read_ack(mem_read_ack), .mem_write_ack(mem_write_ack),
    .mem_read_data(mem_read_data),
    .mem_read_valid(mem_read_valid), .mem_write_valid(mem_write_valid),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .lsu_state(lsu_state), .lsu_read_out(lsu_read_out));

  lsu_array #(.NUM_LANES(NL), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .COALESCE(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .simd_state(simd1),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .lane_mask(lane_mask),
    .rm_data(rm_data), .rn_data(rn_data),
    .mem_read_ack(rack1), .mem_write_ack(wack1),
    .mem_read_data(rdata1),
    .mem_read_valid(rvalid1), .mem_write_valid(wvalid1),
    .mem_addr(addr1), .mem_write_data(wdata1),
    .lsu_state(state1), .lsu_read_out(out1));

  logic [DW-1:0] mem [128];
  logic [DW-1:0] ref_mem [128];
  logic [DW-1:0] cur_out [NL];
  txn_t log_q[$];
  txn_t exp_log[$];
  int unsigned mem_delay;
  int n_rd1;
  int total = 0;
  int bad = 0;
  vec_t tbl[8];

  // dut0 memory: acks after mem_delay cycles of valid, holds ack until valid drops.
  initial begin
    int unsigned wcnt;
    rack_r = 1'b0; wack_r = 1'b0; mem_read_data = '0; wcnt = 0;
    forever begin
      @(negedge clk);
      if (!mem_read_valid && !mem_write_valid) begin
        rack_r = 1'b0; wack_r = 1'b0; wcnt = 0;
      end else if (!rack_r && !wack_r) begin
        if (wcnt >= mem_delay) begin
          if (mem_read_valid) begin
            mem_read_data = mem[mem_addr];
            rack_r = 1'b1;
            log_q.push_back('{wr: 1'b0, addr: mem_addr, data: mem_read_data});
          end else begin
            mem[mem_addr] = mem_write_data;
            wack_r = 1'b1;
            log_q.push_back('{wr: 1'b1, addr: mem_addr, data: mem_write_data});
          end
        end else begin
          wcnt++;
        end
      end
    end
  end

  // dut1 memory: zero-wait, read-only use.
  initial begin
    rack1 = 1'b0; wack1 = 1'b0; rdata1 = '0; n_rd1 = 0;
    forever begin
      @(negedge clk);
      if (rvalid1 && !rack1) begin
        rack1 = 1'b1; rdata1 = mem[addr1]; n_rd1++;
      end else begin
        rack1 = 1'b0;
      end
      wack1 = wvalid1 && !wack1;
    end
  end

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: walk lanes in ascending order; a read serves its lane and,
  // when coalescing, every later active lane with the same address.
  task automatic model_op(input bit rd, input logic [NL-1:0] mask,
                          input logic [NL-1:0][AW-1:0] a, input logic [NL-1:0][DW-1:0] d);
    bit [NL-1:0] served;
    logic [DW-1:0] v;
    served = '0;
    exp_log.delete();
    for (int i = 0; i < NL; i++) begin
      if (mask[i] && !served[i]) begin
        if (rd) begin
          v = ref_mem[a[i]];
          exp_log.push_back('{wr: 1'b0, addr: a[i], data: v});
          for (int j = i; j < NL; j++) begin
            if (mask[j] && !served[j] && (j == i || a[j] == a[i])) begin
              cur_out[j] = v;
              served[j] = 1'b1;
            end
          end
        end else begin
          exp_log.push_back('{wr: 1'b1, addr: a[i], data: d[i]});
          ref_mem[a[i]] = d[i];
          served[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic start_op(input bit rd, input bit wr, input logic [NL-1:0] mask,
                          input logic [NL-1:0][AW-1:0] a, input logic [NL-1:0][DW-1:0] d);
    logic [DW-1:0] tmp;
    for (int i = 0; i < NL; i++) begin
      tmp = {$urandom(), $urandom()};
      tmp[AW-1:0] = a[i];
      rm_data[i*DW +: DW] = tmp;
      rn_data[i*DW +: DW] = d[i];
    end
    MEM_READ = rd; MEM_WRITE = wr; lane_mask = mask;
    simd_state = SIMD_REQUEST;
    model_op(rd, mask, a, d);
    log_q.delete();
  endtask

  task automatic scramble();
    rm_data = {8{$urandom()}};
    rn_data = {8{$urandom()}};
    lane_mask = 4'($urandom());
    MEM_READ = 1'($urandom()); MEM_WRITE = 1'($urandom());
    simd_state = SIMD_WAIT;
  endtask

  task automatic wait_done(input bit jitter, inout int cycles);
    while (lsu_state != ST_DONE && cycles < 400) begin
      @(posedge clk); #1;
      cycles++;
      if (cycles == 1) scramble();
      if (jitter) enable = ($urandom_range(0, 3) != 0);
    end
    enable = 1'b1;
    check("reach_done", 64'(lsu_state), 64'(ST_DONE));
  endtask

  task automatic run_op(input bit rd, input bit wr, input logic [NL-1:0] mask,
                        input logic [NL-1:0][AW-1:0] a, input logic [NL-1:0][DW-1:0] d,
                        input bit jitter, output int cycles);
    enable = 1'b1;
    start_op(rd, wr, mask, a, d);
    cycles = 0;
    wait_done(jitter, cycles);
  endtask

  task automatic check_log(input string tag);
    check($sformatf("%s_ntxn", tag), 64'(log_q.size()), 64'(exp_log.size()));
    for (int k = 0; k < log_q.size() && k < exp_log.size(); k++) begin
      check($sformatf("%s_t%0d_wr", tag, k), 64'(log_q[k].wr), 64'(exp_log[k].wr));
      check($sformatf("%s_t%0d_addr", tag, k), 64'(log_q[k].addr), 64'(exp_log[k].addr));
      check($sformatf("%s_t%0d_data", tag, k), log_q[k].data, exp_log[k].data);
    end
  endtask

  task automatic check_out(input string tag);
    for (int i = 0; i < NL; i++)
      check($sformatf("%s_out%0d", tag, i), lsu_read_out[i*DW +: DW], cur_out[i]);
  endtask

  task automatic finish_op(input string tag);
    @(posedge clk); #1;
    check($sformatf("%s_done_hold", tag), 64'(lsu_state), 64'(ST_DONE));
    simd_state = SIMD_UPDATE;
    @(posedge clk); #1;
    check($sformatf("%s_to_idle", tag), 64'(lsu_state), 64'(ST_IDLE));
    simd_state = SIMD_IDLE;
  endtask

  initial begin
    int cyc;
    int n0;
    int nmis;
    logic [NL-1:0][AW-1:0] ra;
    logic [NL-1:0][DW-1:0] rd_;

    for (int a = 0; a < 128; a++) begin
      mem[a] = 64'(a * 16);
      ref_mem[a] = 64'(a * 16);
    end
    for (int i = 0; i < NL; i++) cur_out[i] = '0;
    winj = 1'b0; mem_delay = 0;
    rst_n = 1'b0; enable = 1'b0; simd_state = SIMD_REQUEST; simd1 = SIMD_IDLE;
    MEM_READ = 1'b1; MEM_WRITE = 1'b0; lane_mask = '1; rm_data = '1; rn_data = '1;

    // Reset wins over enable=0 and a pending request.
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 64'(lsu_state), 64'(ST_IDLE));
    check("rst_rvalid", 64'(mem_read_valid), 64'd0);
    check("rst_wvalid", 64'(mem_write_valid), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_wdata", mem_write_data, 64'd0);
    check_out("rst");
    check("rst_state1", 64'(state1), 64'(ST_IDLE));
    rst_n = 1'b1; enable = 1'b1; simd_state = SIMD_IDLE; MEM_READ = 1'b0;
    @(posedge clk); #1;

    // Directed vectors (lanes listed lane3..lane0); memory holds addr*16.
    tbl[0] = '{1'b1, 1'b0, 4'b1111, {7'd9, 7'd7, 7'd5, 7'd3}, '0, 4, 9,
               {64'd144, 64'd112, 64'd80, 64'd48}};
    tbl[1] = '{1'b0, 1'b1, 4'b0101, {7'd0, 7'd10, 7'd0, 7'd20},
               {64'd0, 64'hAA, 64'd0, 64'hBB}, 2, 5,
               {64'd144, 64'd112, 64'd80, 64'd48}};
    tbl[2] = '{1'b0, 1'b1, 4'b0010, {7'd0, 7'd0, 7'd12, 7'd0},
               {64'd0, 64'd0, 64'h77, 64'd0}, 1, 3,
               {64'd144, 64'd112, 64'd80, 64'd48}};
    tbl[3] = '{1'b1, 1'b0, 4'b1111, {7'd12, 7'd12, 7'd12, 7'd12}, '0, 1, 3,
               {64'h77, 64'h77, 64'h77, 64'h77}};
    tbl[4] = '{1'b1, 1'b0, 4'b0000, {7'd1, 7'd2, 7'd3, 7'd4}, '0, 0, 1,
               {64'h77, 64'h77, 64'h77, 64'h77}};
    tbl[5] = '{1'b1, 1'b0, 4'b1010, {7'd31, 7'd0, 7'd30, 7'd0}, '0, 2, 5,
               {64'd496, 64'h77, 64'd480, 64'h77}};
    tbl[6] = '{1'b1, 1'b0, 4'b1011, {7'd9, 7'd99, 7'd5, 7'd5}, '0, 2, 5,
               {64'd144, 64'h77, 64'd80, 64'd80}};
    tbl[7] = '{1'b1, 1'b1, 4'b0001, {7'd0, 7'd0, 7'd0, 7'd7},
               {64'd0, 64'd0, 64'd0, 64'h5A}, 1, 3,
               {64'd144, 64'h77, 64'd80, 64'd112}};

    for (int r = 0; r < 8; r++) begin
      mem_delay = 0;
      run_op(tbl[r].rd, tbl[r].wr, tbl[r].mask, tbl[r].a, tbl[r].d, 1'b0, cyc);
      check($sformatf("row%0d_cycles", r), 64'(cyc), 64'(tbl[r].exp_cycles));
      check($sformatf("row%0d_ntxn_tbl", r), 64'(log_q.size()), 64'(tbl[r].exp_txn));
      for (int i = 0; i < NL; i++)
        check($sformatf("row%0d_slot%0d", r, i), lsu_read_out[i*DW +: DW], tbl[r].exp_out[i]);
      check_log($sformatf("row%0d", r));
      finish_op($sformatf("row%0d", r));
    end

    // Non-coalescing instance: same address on all lanes gives four reads.
    for (int i = 0; i < NL; i++) rm_data[i*DW +: DW] = {57'($urandom()), 7'd12};
    lane_mask = 4'b1111; MEM_READ = 1'b1; MEM_WRITE = 1'b0;
    simd1 = SIMD_REQUEST; n0 = n_rd1; cyc = 0;
    while (state1 != ST_DONE && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) simd1 = SIMD_WAIT;
    end
    check("nc_cycles", 64'(cyc), 64'd9);
    check("nc_nreads", 64'(n_rd1 - n0), 64'd4);
    for (int i = 0; i < NL; i++)
      check($sformatf("nc_slot%0d", i), out1[i*DW +: DW], 64'h77);
    simd1 = SIMD_UPDATE;
    @(posedge clk); #1;
    check("nc_to_idle", 64'(state1), 64'(ST_IDLE));
    simd1 = SIMD_IDLE;

    // Wait states with enable dropped while the ack is being presented.
    mem_delay = 5;
    ra = {7'd0, 7'd30, 7'd0, 7'd0}; rd_ = '0;
    enable = 1'b1;
    start_op(1'b1, 1'b0, 4'b0100, ra, rd_);
    cyc = 0;
    @(posedge clk); #1; cyc++; scramble();
    @(posedge clk); #1; cyc++;
    check("ws_valid_up", 64'(mem_read_valid), 64'd1);
    repeat (4) begin @(posedge clk); #1; cyc++; end
    enable = 1'b0;
    repeat (2) begin
      @(posedge clk); #1; cyc++;
      check("ws_hold_valid", 64'(mem_read_valid), 64'd1);
      check("ws_hold_state", 64'(lsu_state), 64'(ST_WAIT));
    end
    enable = 1'b1;
    wait_done(1'b0, cyc);
    check_log("ws");
    check_out("ws");
    finish_op("ws");

    // Wrong-type ack during a read is ignored.
    mem_delay = 3;
    ra = {7'd0, 7'd0, 7'd0, 7'd3};
    start_op(1'b1, 1'b0, 4'b0001, ra, rd_);
    cyc = 0;
    @(posedge clk); #1; cyc++; scramble();
    @(posedge clk); #1; cyc++;
    winj = 1'b1;
    @(posedge clk); #1; cyc++;
    winj = 1'b0;
    check("wa_state", 64'(lsu_state), 64'(ST_WAIT));
    check("wa_valid", 64'(mem_read_valid), 64'd1);
    wait_done(1'b0, cyc);
    check_log("wa");
    check_out("wa");
    finish_op("wa");

    // Reset while lane 2 of a load is outstanding.
    mem_delay = 3;
    ra = {7'd43, 7'd42, 7'd41, 7'd40};
    start_op(1'b1, 1'b0, 4'b1111, ra, rd_);
    cyc = 0;
    while (!(lsu_state == ST_WAIT && mem_addr == 7'd42) && cyc < 100) begin
      @(posedge clk); #1; cyc++;
      if (cyc == 1) scramble();
    end
    check("rm_reached_lane2", 64'(mem_addr), 64'd42);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < NL; i++) cur_out[i] = '0;
    check("rm_state", 64'(lsu_state), 64'(ST_IDLE));
    check("rm_rvalid", 64'(mem_read_valid), 64'd0);
    check("rm_wvalid", 64'(mem_write_valid), 64'd0);
    check_out("rm");
    simd_state = SIMD_IDLE;
    @(posedge clk); #1;
    mem_delay = 1;
    ra = {7'd0, 7'd50, 7'd51, 7'd0};
    run_op(1'b1, 1'b0, 4'b0110, ra, rd_, 1'b0, cyc);
    check_log("rm_after");
    check_out("rm_after");
    finish_op("rm_after");

    // Randomized operations with random latency and enable jitter.
    for (int n = 0; n < 40; n++) begin
      bit rd, wr;
      logic [NL-1:0] mask;
      rd = 1'($urandom());
      wr = !rd || 1'($urandom());
      mask = 4'($urandom());
      for (int i = 0; i < NL; i++) begin
        ra[i] = ($urandom_range(0, 1) == 0) ? 7'($urandom_range(0, 3)) : 7'($urandom());
        rd_[i] = {$urandom(), $urandom()};
      end
      mem_delay = $urandom_range(0, 3);
      run_op(rd, wr, mask, ra, rd_, 1'b1, cyc);
      check_log($sformatf("rnd%0d", n));
      check_out($sformatf("rnd%0d", n));
      finish_op($sformatf("rnd%0d", n));
    end
    nmis = 0;
    for (int a = 0; a < 128; a++) if (mem[a] !== ref_mem[a]) nmis++;
    check("mem_contents", 64'(nmis), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_array.md
# lsu_array

Parametrised multi-lane load/store unit for one SIMD core. It captures a per-lane address/data vector and an active-lane mask, then serialises the active lanes onto a single shared data-memory port in ascending lane order. Loads to the same address are optionally coalesced into one memory transaction. The block reports aggregate progress to the SIMD controller through the standard four-state LSU state encoding.

## Interface
Parameters:
- NUM_LANES, 4: lanes served; ≥1.
- DATA_WIDTH, 64: register/memory data width.
- ADDR_WIDTH, 7: memory address width; mem_addr = rm_data[lane][ADDR_WIDTH-1:0].
- COALESCE, 1: 1 = one read ack fills all pending lanes with an equal address; 0 = one transaction per lane.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- enable  in  1  0 = all state and outputs hold.
- simd_state  in  3  SIMD controller state; `SIMD_REQUEST` / `SIMD_UPDATE` from common_defs.v.
- MEM_READ  in  1  load op (Rd = mem[rm]); has priority if both are high.
- MEM_WRITE  in  1  store op (mem[rm] = rn).
- lane_mask  in  NUM_LANES  active lanes; sampled at capture only.
- rm_data  in  NUM_LANES*DATA_WIDTH  per-lane address; lane i at [i*DATA_WIDTH +: DATA_WIDTH].
- rn_data  in  NUM_LANES*DATA_WIDTH  per-lane store data, same packing.
- mem_read_ack  in  1  read completion; mem_read_data valid this cycle.
- mem_write_ack  in  1  write completion.
- mem_read_data  in  DATA_WIDTH  read return data.
- mem_read_valid  out  1  read request; held until ack.
- mem_write_valid  out  1  write request; held until ack.
- mem_addr  out  ADDR_WIDTH  request address.
- mem_write_data  out  DATA_WIDTH  store data.
- lsu_state  out  2  `LSU_IDLE`/`LSU_REQUESTING`/`LSU_WAITING`/`LSU_DONE`.
- lsu_read_out  out  NUM_LANES*DATA_WIDTH  per-lane load results, same packing.

## Operation
- Reset (rst_n=0 at a clock edge): lsu_state=IDLE; pending mask, captured op, captured address/data registers, mem_read_valid, mem_write_valid, mem_addr, mem_write_data and lsu_read_out all 0. Reset overrides enable and aborts any in-flight transaction; valid drops the next edge.
- IDLE: if simd_state==SIMD_REQUEST and (MEM_READ|MEM_WRITE): capture op (read wins), lane_mask into pending, all rm/rn lanes into internal registers. If lane_mask==0 → DONE; else → REQUESTING. Otherwise stay.
- REQUESTING: select lowest-index pending lane L; drive mem_addr=addr[L], mem_write_data=data[L] (stores only), assert the matching valid; → WAITING.
- WAITING: ack accepted only for the current op while its valid is high. Read ack: lane L slot of lsu_read_out = mem_read_data; if COALESCE, every pending lane with addr equal to addr[L] (ADDR_WIDTH bits) also gets mem_read_data and is cleared. Write ack: clear L only (stores never coalesce). On ack, valid → 0; if pending remains → REQUESTING, else → DONE. No ack: hold everything.
- DONE: on simd_state==SIMD_UPDATE → IDLE; else hold.
- Inputs after capture (rm/rn/lane_mask/MEM_*) are ignored until next IDLE capture.
- lsu_read_out slots of inactive lanes, and all slots during stores, retain previous value.
- Wrong-type ack (e.g. mem_write_ack during a read) or ack with valid low: ignored.

## Timing
- Capture to first valid: 2 edges (IDLE→REQUESTING, REQUESTING→WAITING with valid registered).
- Per transaction: 1 REQUESTING cycle + ≥1 WAITING cycle; valid deasserts the edge after the ack-sampling edge and stays low for ≥1 cycle between lanes.
- Ack in the first WAITING cycle is legal; minimum per lane = 2 cycles.
- K distinct active lanes, zero-wait memory: IDLE exit to DONE = 2K cycles.
- lsu_read_out updated on the ack edge; stable from DONE until next capture.
- enable=0 mid-transaction: FSM and valid hold; acks arriving while enable=0 are lost (memory must hold ack until sampled).

## Test plan
- Load, mask 4'b1111, addrs 3,5,7,9, memory returns addr*16, ack 1 cycle after valid: 4 transactions in order 3,5,7,9; lsu_read_out = {144,112,80,48}; DONE after 8 cycles; IDLE after SIMD_UPDATE.
- Store, mask 4'b0101, rm={_,10,_,20}, rn={_,0xAA,_,0xBB}: exactly 2 writes, lane0 (addr 20, 0xBB) then lane2 (addr 10, 0xAA); mem_write_valid low after each ack; lsu_read_out unchanged.
- Coalesced load, COALESCE=1, all lanes addr 12, data 0x77: one read; all four slots = 0x77. Repeat with COALESCE=0: four reads.
- lane_mask=0 with MEM_READ: IDLE→DONE in 1 cycle, no valid ever asserted.
- Wait states + enable: ack delayed 5 cycles, enable low 2 cycles mid-WAITING: valid held throughout, correct data captured, no duplicate request.
- rst_n low while WAITING on lane 2 of a load: next cycle state IDLE, valids 0, lsu_read_out 0; new request completes normally.
